// File: rtl/softmax_row_packer_if.sv
// softmax_row_packer_if: handshake bundle between the softmax element stream,
// the row packer and the attention-times-V consumer.
//   master : producer/consumer side (drives elements, stall and ready)
//   slave  : the packer itself
interface softmax_row_packer_if #(
    parameter int D_W   = 8,
    parameter int N     = 32,
    parameter int RID_W = 16
) ();
    logic               enable;
    logic               in_valid;
    logic [D_W-1:0]     qin;
    logic               out_valid;
    logic               out_ready;
    logic [N*D_W-1:0]   out_data;
    logic [RID_W-1:0]   out_row_id;
    logic               overflow;
    logic               busy;

    modport master (
        output enable, in_valid, qin, out_ready,
        input  out_valid, out_data, out_row_id, overflow, busy
    );

    modport slave (
        input  enable, in_valid, qin, out_ready,
        output out_valid, out_data, out_row_id, overflow, busy
    );
endinterface

// File: rtl/softmax_row_packer.sv
// softmax_row_packer: collects serial int8 softmax probabilities, N per row,
// into a two-bank ping-pong buffer and presents each finished row as one wide
// word with a valid/ready handshake. The softmax side cannot be stalled, so a
// row that starts while both banks still hold unconsumed rows is dropped in
// full and the sticky overflow flag is raised.
//
// Optional feature macro: SOFTMAX_PACK_CLAMP_EN
//   defined   -> each element is clamped to [0, 2^OUT_BITS] before storage
//   undefined -> elements are stored bit-exact, no clamp logic exists
module softmax_row_packer #(
    parameter int D_W      = 8,
    parameter int N        = 32,
    parameter int OUT_BITS = 6,
    parameter int RID_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    softmax_row_packer_if.slave   bus
);

    localparam int COL_W = $clog2(N);
    localparam logic [COL_W-1:0] COL_FIRST = {COL_W{1'b0}};
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(N - 1);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [RID_W-1:0] RID_ONE   = RID_W'(1);

    // Clamp ceiling only matters when the macro is on; keep the parameter
    // referenced so the plain build carries no dangling configuration.
    logic unused_cfg_s;
    assign unused_cfg_s = (OUT_BITS > 0);

    // Element conditioning applied on the way into the row buffer.
    function automatic logic [D_W-1:0] store_elem(input logic [D_W-1:0] v);
`ifdef SOFTMAX_PACK_CLAMP_EN
        int sv_i;
        int ceil_i;
        ceil_i = 32'sd1 <<< OUT_BITS;
        sv_i   = int'($signed(v));
        if (sv_i < 32'sd0) begin
            store_elem = {D_W{1'b0}};
        end else if (sv_i > ceil_i) begin
            store_elem = D_W'(ceil_i);
        end else begin
            store_elem = v;
        end
`else
        store_elem = v;
`endif
    endfunction

    // State
    logic [N*D_W-1:0]  bank_r [0:1];
    logic [1:0]        full_r;
    logic              wr_bank_r;
    logic              rd_bank_r;
    logic [COL_W-1:0]  col_r;
    logic              drop_row_r;
    logic [RID_W-1:0]  row_cnt_r;
    logic              overflow_r;

    // Per-cycle decisions
    logic              accept_s;
    logic              drop_now_s;
    logic              write_s;
    logic              row_end_s;
    logic              row_commit_s;
    logic              transfer_s;
    logic [1:0]        full_next_s;
    logic [D_W-1:0]    elem_s;

    // Decode this cycle's accept/drop/commit/transfer events from pre-edge state.
    always_comb begin
        accept_s     = bus.enable & bus.in_valid;
        // A row may only start into a free bank; the check deliberately uses
        // the pre-edge full flags, so a bank freed this same cycle is not yet
        // available to a row starting now.
        drop_now_s   = accept_s & (col_r == COL_FIRST) & full_r[wr_bank_r];
        write_s      = accept_s & ~drop_now_s & ~drop_row_r;
        row_end_s    = accept_s & (col_r == COL_LAST);
        row_commit_s = row_end_s & ~drop_row_r;
        transfer_s   = bus.enable & full_r[rd_bank_r] & bus.out_ready;
        elem_s       = store_elem(bus.qin);
    end

    // Next value of the bank-occupied flags: release on transfer, claim on commit.
    always_comb begin
        full_next_s = full_r;
        if (transfer_s) begin
            full_next_s[rd_bank_r] = 1'b0;
        end else begin
            full_next_s[rd_bank_r] = full_r[rd_bank_r];
        end
        // A committing row never targets the bank being read out: it started
        // into a free bank, and the read side only releases full banks.
        if (row_commit_s) begin
            full_next_s[wr_bank_r] = 1'b1;
        end else begin
            full_next_s[wr_bank_r] = full_next_s[wr_bank_r];
        end
    end

    // Row buffer storage: one element per accepted, non-dropped beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_r[0] <= {(N*D_W){1'b0}};
            bank_r[1] <= {(N*D_W){1'b0}};
        end else if (write_s) begin
            bank_r[wr_bank_r][col_r*D_W +: D_W] <= elem_s;
        end
    end

    // Write-side sequencing: column position, drop marker, bank ping-pong.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r      <= COL_FIRST;
            drop_row_r <= 1'b0;
            wr_bank_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            // Column advances on every accepted beat, dropped or not, so the
            // next row stays aligned with the upstream row boundaries.
            if (accept_s) begin
                if (row_end_s) begin
                    col_r      <= COL_FIRST;
                    drop_row_r <= 1'b0;
                end else begin
                    col_r <= col_r + COL_ONE;
                    if (drop_now_s) begin
                        drop_row_r <= 1'b1;
                    end
                end
            end
            if (row_commit_s) begin
                wr_bank_r <= ~wr_bank_r;
            end
            if (drop_now_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Read-side sequencing: occupancy flags, read bank and emitted-row count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r    <= 2'b00;
            rd_bank_r <= 1'b0;
            row_cnt_r <= {RID_W{1'b0}};
        end else begin
            full_r <= full_next_s;
            if (transfer_s) begin
                rd_bank_r <= ~rd_bank_r;
                row_cnt_r <= row_cnt_r + RID_ONE;
            end
        end
    end

    // Outputs are straight decodes of registered state; out_data is a plain
    // bank select and therefore holds still while out_valid waits for ready.
    assign bus.out_valid  = full_r[rd_bank_r];
    assign bus.out_data   = bank_r[rd_bank_r];
    assign bus.out_row_id = row_cnt_r;
    assign bus.overflow   = overflow_r;
    assign bus.busy       = (|full_r) | (col_r != COL_FIRST);

endmodule

// File: tb/tb_softmax_row_packer.sv
// tb_softmax_row_packer: scenario tasks drive softmax_row_packer and compare
// its outputs every cycle with a queue-based model of held rows.
module tb_softmax_row_packer;

    localparam int D_W   = 8;
    localparam int N     = 32;
    localparam int RID_W = 16;

    typedef logic [N*D_W-1:0] row_t;

    logic clk;
    logic rst;

    softmax_row_packer_if #(.D_W(D_W), .N(N), .RID_W(RID_W)) bus ();

    softmax_row_packer #(.D_W(D_W), .N(N), .OUT_BITS(6), .RID_W(RID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: rows waiting for the consumer, oldest first (at most 2).
    row_t             held_q[$];
    row_t             m_cur;
    int               m_col;
    bit               m_dropping;
    bit               m_ovf;
    logic [RID_W-1:0] m_id;

    function automatic logic [7:0] store_val(input logic [7:0] q);
        int v;
        v = int'($signed(q));
`ifdef SOFTMAX_PACK_CLAMP_EN
        if (v < 0) return 8'd0;
        if (v > 64) return 8'd64;
`endif
        return q;
    endfunction

    function automatic bit m_busy();
        return (held_q.size() > 0) || (m_col != 0);
    endfunction

    task automatic model_clear();
        held_q.delete();
        m_cur = '0; m_col = 0; m_dropping = 0; m_ovf = 0; m_id = '0;
    endtask

    // Drive one cycle (from a negedge), advance the model at the posedge,
    // return at the following negedge where outputs are sampled.
    task automatic tick(input bit en, input bit iv, input logic [7:0] q, input bit rdy);
        bit start_drop;
        bus.enable = en; bus.in_valid = iv; bus.qin = q; bus.out_ready = rdy;
        @(posedge clk);
        if (en) begin
            // Space check sees the buffer before this edge's transfer.
            start_drop = iv && (m_col == 0) && (held_q.size() == 2);
            if (start_drop) begin m_dropping = 1; m_ovf = 1; end
            if (iv && !m_dropping) m_cur[m_col*D_W +: D_W] = store_val(q);
            if (rdy && held_q.size() > 0) begin
                void'(held_q.pop_front());
                m_id = m_id + 1'b1;
            end
            if (iv) begin
                if (m_col == N-1) begin
                    if (!m_dropping) held_q.push_back(m_cur);
                    m_dropping = 0;
                    m_col = 0;
                end else begin
                    m_col++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.enable = 1'b0; bus.in_valid = 1'b0; bus.qin = 8'd0; bus.out_ready = 1'b0;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.in_valid = 1'b0; bus.qin = 8'd0; bus.out_ready = 1'b0;
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", bus.out_data); end
        checks++; if (bus.out_row_id !== '0) begin errors++; $display("FAIL reset_id got=%0d want=0", bus.out_row_id); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b want=0", bus.overflow); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
        rst = 1'b0;
    endtask

    task automatic test_single_row();
        do_reset();
        for (int k = 0; k < N + 2; k++) begin
            tick(1'b1, k < N, 8'(k), 1'b1);
            checks++; if (bus.out_valid !== (held_q.size() > 0)) begin errors++; $display("FAIL single_valid k=%0d got=%0b want=%0b", k, bus.out_valid, held_q.size() > 0); end
            checks++; if (bus.busy !== m_busy()) begin errors++; $display("FAIL single_busy k=%0d got=%0b want=%0b", k, bus.busy, m_busy()); end
            if (k == N-1) begin
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_latency got=%0b want=1", bus.out_valid); end
                checks++; if (bus.out_row_id !== 16'd0) begin errors++; $display("FAIL single_id got=%0d want=0", bus.out_row_id); end
                for (int e = 0; e < N; e++) begin
                    checks++;
                    if (bus.out_data[e*D_W +: D_W] !== 8'(e)) begin
                        errors++; $display("FAIL single_elem e=%0d got=%0d want=%0d", e, bus.out_data[e*D_W +: D_W], e);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        do_reset();
        for (int c = 0; c < 4*N + 3; c++) begin
            tick(1'b1, c < 4*N, 8'($urandom), 1'b1);
            checks++; if (bus.out_valid !== (held_q.size() > 0)) begin errors++; $display("FAIL b2b_valid c=%0d got=%0b want=%0b", c, bus.out_valid, held_q.size() > 0); end
            if (held_q.size() > 0) begin
                checks++; if (bus.out_data !== held_q[0]) begin errors++; $display("FAIL b2b_data got=%h want=%h", bus.out_data, held_q[0]); end
                checks++; if (bus.out_row_id !== 16'(pulses)) begin errors++; $display("FAIL b2b_id got=%0d want=%0d", bus.out_row_id, pulses); end
            end
            if (bus.out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_pulses got=%0d want=4", pulses); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%0b want=0", bus.overflow); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 3*N; c++) begin
            tick(1'b1, 1'b1, 8'(c / N + 1), 1'b0);
            checks++; if (bus.out_valid !== (held_q.size() > 0)) begin errors++; $display("FAIL bp_valid c=%0d got=%0b want=%0b", c, bus.out_valid, held_q.size() > 0); end
            checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL bp_ovf c=%0d got=%0b want=%0b", c, bus.overflow, m_ovf); end
            checks++; if (bus.busy !== m_busy()) begin errors++; $display("FAIL bp_busy c=%0d got=%0b want=%0b", c, bus.busy, m_busy()); end
        end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_set got=%0b want=1", bus.overflow); end
        checks++; if (bus.out_data !== {N{8'h01}}) begin errors++; $display("FAIL bp_first_row got=%h want=all 01", bus.out_data); end
        for (int c = 0; c < 4; c++) begin
            tick(1'b1, 1'b0, 8'd0, 1'b1);
            checks++; if (bus.out_valid !== (held_q.size() > 0)) begin errors++; $display("FAIL bp_drain_valid c=%0d got=%0b want=%0b", c, bus.out_valid, held_q.size() > 0); end
            if (held_q.size() > 0) begin
                checks++; if (bus.out_data !== held_q[0]) begin errors++; $display("FAIL bp_drain_data got=%h want=%h", bus.out_data, held_q[0]); end
                checks++; if (bus.out_row_id !== m_id) begin errors++; $display("FAIL bp_drain_id got=%0d want=%0d", bus.out_row_id, m_id); end
            end
            if (c == 0) begin
                checks++; if (bus.out_data !== {N{8'h02}} || bus.out_row_id !== 16'd1) begin errors++; $display("FAIL bp_second_row got=%h id=%0d want=all 02 id=1", bus.out_data, bus.out_row_id); end
            end
        end
        checks++; if (bus.out_row_id !== 16'd2) begin errors++; $display("FAIL bp_final_id got=%0d want=2", bus.out_row_id); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky got=%0b want=1", bus.overflow); end
    endtask

    // Pulse out_ready either on element 0 of the third row (early=0) or one
    // cycle before it (early=1).
    task automatic run_simultaneous(input bit early);
        do_reset();
        for (int c = 0; c < 2*N; c++) tick(1'b1, 1'b1, 8'($urandom), 1'b0);
        if (early) tick(1'b1, 1'b0, 8'd0, 1'b1);
        for (int c = 0; c < N + 6; c++) begin
            tick(1'b1, c < N, 8'($urandom), (c == 0 && !early) || c >= N);
            checks++; if (bus.out_valid !== (held_q.size() > 0)) begin errors++; $display("FAIL sim%0d_valid c=%0d got=%0b want=%0b", early, c, bus.out_valid, held_q.size() > 0); end
            if (held_q.size() > 0) begin
                checks++; if (bus.out_data !== held_q[0]) begin errors++; $display("FAIL sim%0d_data got=%h want=%h", early, bus.out_data, held_q[0]); end
                checks++; if (bus.out_row_id !== m_id) begin errors++; $display("FAIL sim%0d_id got=%0d want=%0d", early, bus.out_row_id, m_id); end
            end
            checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL sim%0d_ovf c=%0d got=%0b want=%0b", early, c, bus.overflow, m_ovf); end
        end
        checks++; if (bus.overflow !== !early) begin errors++; $display("FAIL sim%0d_drop got=%0b want=%0b", early, bus.overflow, !early); end
        checks++; if (bus.out_row_id !== (early ? 16'd3 : 16'd2)) begin errors++; $display("FAIL sim%0d_rows got=%0d want=%0d", early, bus.out_row_id, early ? 3 : 2); end
    endtask

    task automatic test_simultaneous();
        run_simultaneous(1'b0);
        run_simultaneous(1'b1);
    endtask

    task automatic test_enable_stall();
        do_reset();
        for (int c = 0; c < N + 7; c++) begin
            bit en;
            en = !(c >= 10 && c < 15);
            tick(en, en ? (c < N + 5) : c[0], 8'($urandom), 1'b0);
            checks++; if (bus.out_valid !== (held_q.size() > 0)) begin errors++; $display("FAIL stall_valid c=%0d got=%0b want=%0b", c, bus.out_valid, held_q.size() > 0); end
            checks++; if (bus.busy !== m_busy()) begin errors++; $display("FAIL stall_busy c=%0d got=%0b want=%0b", c, bus.busy, m_busy()); end
            if (held_q.size() > 0) begin
                checks++; if (bus.out_data !== held_q[0]) begin errors++; $display("FAIL stall_data got=%h want=%h", bus.out_data, held_q[0]); end
            end
        end
        // Ready during a stall must not consume the held row.
        tick(1'b0, 1'b0, 8'd0, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got=%0b want=1", bus.out_valid); end
        // Asynchronous reset mid-row with a row held.
        #2 rst = 1'b1;
        #1;
        model_clear();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b want=0", bus.busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clamp();
        logic [7:0] want0, want1;
`ifdef SOFTMAX_PACK_CLAMP_EN
        want0 = 8'd0;  want1 = 8'd64;
`else
        want0 = 8'hFB; want1 = 8'd100;
`endif
        do_reset();
        for (int c = 0; c < N; c++)
            tick(1'b1, 1'b1, (c == 0) ? 8'hFB : (c == 1) ? 8'd100 : 8'($urandom), 1'b0);
        checks++; if (bus.out_data[7:0] !== want0) begin errors++; $display("FAIL clamp_neg got=%h want=%h", bus.out_data[7:0], want0); end
        checks++; if (bus.out_data[15:8] !== want1) begin errors++; $display("FAIL clamp_big got=%h want=%h", bus.out_data[15:8], want1); end
        checks++; if (bus.out_data !== held_q[0]) begin errors++; $display("FAIL clamp_row got=%h want=%h", bus.out_data, held_q[0]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bit rdy;
            rdy = (c % 300 < 150) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            tick($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, 8'($urandom), rdy);
            checks++; if (bus.out_valid !== (held_q.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, bus.out_valid, held_q.size() > 0); end
            if (held_q.size() > 0) begin
                checks++; if (bus.out_data !== held_q[0]) begin errors++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, bus.out_data, held_q[0]); end
                checks++; if (bus.out_row_id !== m_id) begin errors++; $display("FAIL rnd_id c=%0d got=%0d want=%0d", c, bus.out_row_id, m_id); end
            end
            checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c=%0d got=%0b want=%0b", c, bus.overflow, m_ovf); end
            checks++; if (bus.busy !== m_busy()) begin errors++; $display("FAIL rnd_busy c=%0d got=%0b want=%0b", c, bus.busy, m_busy()); end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.enable = 1'b0; bus.in_valid = 1'b0; bus.qin = 8'd0; bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_row();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_enable_stall();
        test_clamp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
